// File: rtl/ttrng_pkg.sv
// ttrng_pkg: shared state encoding and widths for the ttrng scheduler
package ttrng_pkg;
   typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;
   localparam int SEL_W = 2;
   localparam int NUM_W = 8;
endpackage

// File: rtl/ttrng_rr_arbiter.sv
// ttrng_rr_arbiter: combinational rotate-priority pick of the first request at or after the pointer
module ttrng_rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] i_req,
   input  logic [ID_W-1:0]  i_ptr,
   output logic             o_any,
   output logic [ID_W-1:0]  o_winner
);
   logic [ID_W-1:0] w_idx;
   always_comb begin
      o_any    = |i_req;
      o_winner = '0;
      w_idx    = '0;
      // Walk from farthest to nearest so the closest set bit overwrites last
      for (int k = N_REQ - 1; k >= 0; k--) begin
         w_idx = ID_W'((int'(i_ptr) + k) % N_REQ);
         if (i_req[w_idx]) o_winner = w_idx;
      end
   end
endmodule

// File: rtl/ttrng_sched.sv
// ttrng_sched: round-robin sharing of the single ttrng entropy core among N_REQ requesters.
// Grants one requester, holds its source selector for SETTLE_CYCLES, then captures the byte.
module ttrng_sched
   import ttrng_pkg::*;
#(
   parameter int N_REQ         = 4,
   parameter int SETTLE_CYCLES = 1000,
   parameter int ID_W          = $clog2(N_REQ),
   parameter int CNT_W         = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     ena,
   input  logic [N_REQ-1:0]         req,
   input  logic [SEL_W*N_REQ-1:0]   req_sel,
   output logic [N_REQ-1:0]         gnt,
   output logic [N_REQ-1:0]         done,
   output logic [NUM_W-1:0]         rsp_data,
   output logic [ID_W-1:0]          rsp_id,
   output logic                     busy,
   output logic [SEL_W-1:0]         rng_selector,
   input  logic [NUM_W-1:0]         rng_number
);
   state_t            r_state, w_next;
   logic [N_REQ-1:0]  r_gnt, r_done;
   logic [NUM_W-1:0]  r_data;
   logic [ID_W-1:0]   r_id, r_ptr, w_winner;
   logic [SEL_W-1:0]  r_sel;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_busy, w_any;
   logic [SEL_W-1:0]  w_sel_arr [N_REQ];

   for (genvar i = 0; i < N_REQ; i++) begin : g_sel
      assign w_sel_arr[i] = req_sel[SEL_W*i +: SEL_W];
   end

   ttrng_rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
      .i_req   (req),
      .i_ptr   (r_ptr),
      .o_any   (w_any),
      .o_winner(w_winner)
   );

   always_comb begin
      w_next = r_state;
      // A dropped request aborts even on the final settle cycle, so nothing is captured
      w_next = (r_state == IDLE)   ? ((ena && w_any) ? SETTLE : IDLE) :
               (r_state == SETTLE) ? (!req[r_id] ? IDLE : (r_cnt == '0) ? DONE : SETTLE) :
                                     IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_gnt  <= '0;
         r_done <= '0;
         r_data <= '0;
         r_id   <= '0;
         r_sel  <= '0;
         r_busy <= 1'b0;
         r_ptr  <= '0;
         r_cnt  <= '0;
      end else begin
         r_done <= '0;
         r_busy <= (w_next != IDLE);
         if (r_state == IDLE && w_next == SETTLE) begin
            r_gnt <= N_REQ'(1) << w_winner;
            r_sel <= w_sel_arr[w_winner];
            r_id  <= w_winner;
            r_cnt <= CNT_W'(SETTLE_CYCLES - 1);
            r_ptr <= (w_winner == ID_W'(N_REQ - 1)) ? '0 : w_winner + 1'b1;
         end
         if (r_state == SETTLE) r_cnt <= r_cnt - 1'b1;
         if (w_next == DONE) begin
            r_data <= rng_number;
            r_done <= r_gnt;
         end
         if (r_state != IDLE && w_next == IDLE) r_gnt <= '0;
      end
   end

   assign gnt          = r_gnt;
   assign done         = r_done;
   assign rsp_data     = r_data;
   assign rsp_id       = r_id;
   assign busy         = r_busy;
   assign rng_selector = r_sel;
endmodule

// File: tb/tb_ttrng_sched.sv
// tb_ttrng_sched: randomized transactions against a transaction-level model, checked by a scoreboard monitor
module tb_ttrng_sched;
   logic       clk, rst, ena;
   logic [3:0] req, gnt, done;
   logic [7:0] req_sel, rsp_data, rng_number;
   logic [1:0] rsp_id, rng_selector;
   logic       busy;

   typedef struct {
      int         id;
      logic [1:0] sel;
      int         gnt_cyc, done_cyc, fall_cyc;
      logic [7:0] data;
      bit         abort;
   } exp_t;

   exp_t       q[$];
   exp_t       e;
   logic [7:0] tab [1024];
   int         cyc = 0, n_tests = 0, n_fail = 0, m_ptr = 0, last_done = 0;
   logic [7:0] m_data = 8'h00;
   logic [3:0] prev_gnt = 4'h0;
   bit         mon_en = 0;

   ttrng_sched #(.N_REQ(4), .SETTLE_CYCLES(4)) dut (
      .clk(clk), .rst(rst), .ena(ena), .req(req), .req_sel(req_sel),
      .gnt(gnt), .done(done), .rsp_data(rsp_data), .rsp_id(rsp_id),
      .busy(busy), .rng_selector(rng_selector), .rng_number(rng_number)
   );

   initial clk = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   assign rng_number = tab[cyc % 1024];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int pick(input logic [3:0] m, input int p);
      for (int k = 0; k < 4; k++) if (m[(p + k) % 4]) return (p + k) % 4;
      return 0;
   endfunction

   task automatic chk_reset_state(input string nm);
      chk({nm, "_gnt"}, gnt, 0);
      chk({nm, "_done"}, done, 0);
      chk({nm, "_data"}, rsp_data, 0);
      chk({nm, "_id"}, rsp_id, 0);
      chk({nm, "_sel"}, rng_selector, 0);
      chk({nm, "_busy"}, busy, 0);
   endtask

   // kind: 0 normal, 1 ena drops mid-flight, 2 abort by dropping req, 3 reset mid-flight
   task automatic issue(input logic [3:0] m, input logic [7:0] s, input int kind);
      int   t = cyc;
      int   w = pick(m, m_ptr);
      exp_t x;
      ena = 1; req = m; req_sel = s;
      x.id = w; x.sel = s[2*w +: 2]; x.gnt_cyc = t + 1; x.done_cyc = t + 5; x.fall_cyc = t + 3;
      x.abort = (kind >= 2);
      x.data = (kind == 3) ? 8'h00 : (kind == 2) ? m_data : tab[(t + 4) % 1024];
      q.push_back(x);
      m_ptr = (w + 1) % 4;
      if (kind < 2) m_data = x.data;
      repeat (2) step();
      if (kind == 1) ena = 0;
      if (kind == 2) req = 0;
      if (kind == 3) begin rst = 1; req = 0; end
      step();
      if (kind == 3) begin
         rst = 0; m_ptr = 0; m_data = 0;
         chk_reset_state("midflight_rst");
      end
      if (kind < 2) repeat (3) step();
   endtask

   always @(negedge clk) if (mon_en) begin
      if (gnt != 0 && prev_gnt == 0) begin
         if (q.size() == 0) chk("unexpected_gnt", gnt, 0);
         else begin
            chk("gnt_onehot", gnt, 1 << q[0].id);
            chk("gnt_cycle", cyc, q[0].gnt_cyc);
            chk("rng_selector", rng_selector, q[0].sel);
            chk("rsp_id", rsp_id, q[0].id);
            chk("busy_on", busy, 1);
         end
      end
      if (done != 0) begin
         if (q.size() == 0 || q[0].abort) chk("unexpected_done", done, 0);
         else begin
            e = q.pop_front();
            chk("done_onehot", done, 1 << e.id);
            chk("done_cycle", cyc, e.done_cyc);
            chk("rsp_data", rsp_data, e.data);
            chk("gnt_held", gnt, 1 << e.id);
            last_done = cyc;
         end
      end
      if (gnt == 0 && prev_gnt != 0) begin
         if (q.size() != 0 && q[0].abort) begin
            e = q.pop_front();
            chk("abort_cycle", cyc, e.fall_cyc);
            chk("abort_data", rsp_data, e.data);
         end else chk("gnt_release_cycle", cyc, last_done + 1);
         chk("busy_off", busy, 0);
      end
      prev_gnt = gnt;
   end

   initial begin
      for (int i = 0; i < 1024; i++) tab[i] = (i < 256) ? 8'(i) : 8'($urandom);
      rst = 1; ena = 0; req = 0; req_sel = 0;
      repeat (3) step();
      chk_reset_state("reset");
      rst = 0; mon_en = 1;
      step();
      issue(4'b0001, 8'b01, 0);
      req = 0; step();
      for (int i = 0; i < 5; i++) issue(4'b1111, 8'($urandom), 0);
      req = 0; step();
      issue(4'b0010, 8'($urandom), 2);
      issue(4'b0011, 8'($urandom), 0);
      req = 0; step();
      issue(4'b0100, 8'($urandom), 3);
      ena = 0; req = 4'b0100;
      repeat (10) begin
         step();
         chk("ena_blocks_gnt", gnt, 0);
      end
      issue(4'b0100, 8'($urandom), 0);
      for (int i = 0; i < 50; i++) begin
         int r = $urandom_range(0, 9);
         issue(4'($urandom_range(1, 15)), 8'($urandom), r < 6 ? 0 : r < 8 ? 1 : r == 8 ? 2 : 3);
         if ($urandom_range(0, 3) == 0) begin ena = 1; req = 0; step(); end
      end
      req = 0; ena = 1;
      repeat (10) step();
      chk("scoreboard_drained", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/ttrng_sched.md
Name: ttrng_sched

Overview:
- Round-robin scheduler that shares the single ttrng entropy core between N_REQ on-chip requesters.
- Each requester asks for one byte from a chosen oscillator source (2-bit selector).
- The scheduler grants one requester, drives the core's selector, waits SETTLE_CYCLES for the selected source to settle, captures the 8-bit number, and returns it with a done pulse.
- Sits between the ttrng core and the user-facing logic inside tt_um_ttrng.

Parameters:
- N_REQ, 4, number of requesters; must be at least 2.
- SETTLE_CYCLES, 1000, cycles the selector is held before capture; must be at least 1. Matches the core's MAX_COUNT.
- ID_W, $clog2(N_REQ), derived width of requester index.
- CNT_W, $clog2(SETTLE_CYCLES), derived settle-counter width; minimum 1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- ena  in  1  design enable; 0 blocks new grants
- req  in  N_REQ  per-requester level request
- req_sel  in  2*N_REQ  source select; requester i uses bits [2i+1:2i]
- gnt  out  N_REQ  one-hot grant, held for the whole transaction
- done  out  N_REQ  one-hot, one-cycle completion pulse
- rsp_data  out  8  captured random byte
- rsp_id  out  ID_W  index of the requester served last
- busy  out  1  high in any state other than IDLE
- rng_selector  out  2  drives the ttrng core selector
- rng_number  in  8  ttrng core output

Behaviour:
- All outputs and state are registered.
- Reset (rst=1 at a clk edge) sets:
  - state=IDLE, gnt=0, done=0, rsp_data=0, rsp_id=0, rng_selector=0, busy=0
  - round-robin pointer=0, counter=0
- Reset overrides everything, including an in-flight transaction. No done is issued for that transaction.

States: IDLE, SETTLE, DONE.

- IDLE:
  - If ena=1 and req is nonzero at cycle t, select the first set req bit at or after the pointer (wrapping).
  - At t+1: state=SETTLE, gnt=onehot(winner), rng_selector=req_sel[winner] (latched; later changes ignored), rsp_id=winner, counter=SETTLE_CYCLES-1, pointer=(winner+1) mod N_REQ.
  - If ena=0 or req=0: stay in IDLE.
- SETTLE:
  - Counter decrements each cycle.
  - In the cycle where counter==0: rsp_data<=rng_number; next state DONE.
  - The SETTLE state therefore spans exactly SETTLE_CYCLES cycles (t+1 to t+SETTLE_CYCLES).
- DONE (cycle t+SETTLE_CYCLES+1):
  - done=onehot(winner) for this cycle only; rsp_data is valid.
  - Next state IDLE; gnt clears at the following edge.
- Back-to-back: arbitration happens in the IDLE cycle (t+SETTLE_CYCLES+2), so the next grant appears at t+SETTLE_CYCLES+3. Pass period is SETTLE_CYCLES+2 cycles.
- Abort: if req[winner] drops during SETTLE:
  - Next state is IDLE; gnt clears; no done; rsp_data is unchanged.
  - The pointer keeps its advanced value.
  - A drop during the DONE cycle has no effect.
- ena falling during SETTLE/DONE: the transaction completes normally; only new grants are blocked.
- rsp_data and rsp_id hold their last values until the next capture/grant.
- rng_selector holds its last value while idle.
- A requester that keeps req high after done is eligible again, but round-robin ordering applies.
- Pointer wrap: from N_REQ-1 to 0.

Decomposition:
- Package ttrng_pkg contains:
  - state enum {IDLE, SETTLE, DONE}
  - SEL_W=2, NUM_W=8 constants
- Sub-module ttrng_rr_arbiter: combinational rotate-priority selector.
  - Inputs: req, pointer.
  - Outputs: any, winner index.
- FSM, counter and capture registers live in ttrng_sched.

Test Plan (bench uses N_REQ=4, SETTLE_CYCLES=4):
- Single request:
  - Stimulus: req=4'b0001 at t, req_sel[1:0]=2'b01, rng_number=8'hA5 steady.
  - Response: gnt=0001 and rng_selector=01 at t+1; done=0001 at t+5; rsp_data=8'hA5; rsp_id=0; busy low at t+6.
- Round robin:
  - Stimulus: req=4'b1111 held.
  - Response: grants go to requesters 0,1,2,3,0 at t+1, t+7, t+13, t+19, t+25; exactly one done per grant.
- Capture timing:
  - Stimulus: rng_number changes every cycle (value = cycle index).
  - Response: rsp_data equals the value present in the last SETTLE cycle (t+4), not t+5.
- Abort:
  - Stimulus: req=4'b0010, then drop req[1] at t+2.
  - Response: gnt=0 at t+3; no done pulse; rsp_data unchanged; next req=4'b0011 grants requester 0 (pointer=2 wraps to 0).
- Reset and enable:
  - Stimulus: rst=1 during SETTLE.
  - Response: next cycle gnt=0, done=0, rsp_data=0, rng_selector=0, busy=0.
  - Stimulus: then ena=0 with req=4'b0100.
  - Response: no grant for 10 cycles; after ena is raised at cycle u, gnt=0100 at u+1.
